// File: rtl/mem_if_arbiter_pkg.sv
// Shared definitions for the L1 I/D memory interface arbiter.
package mem_if_arbiter_pkg;

  localparam int DFLT_WORD_LENGTH = 32;
  localparam int DFLT_LINE_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_burst_seq.sv
// Burst sequencer: holds the line-aligned base address and the word counter,
// produces the current word byte address and flags the last word of the line.
module mem_burst_seq
  import mem_if_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH = DFLT_WORD_LENGTH,
  parameter int LINE_WORDS  = DFLT_LINE_WORDS,
  localparam int IDXW       = $clog2(LINE_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] startAdr,
  input  logic                   advance,
  output logic [IDXW-1:0]        wordCnt,
  output logic [WORD_LENGTH-1:0] wordAdr,
  output logic                   last
);

  // Byte-offset bits covering one whole line; cleared to align the base.
  localparam logic [WORD_LENGTH-1:0] OFF_MASK = WORD_LENGTH'((1 << (IDXW + 2)) - 1);

  logic [WORD_LENGTH-1:0] base;

  // Word counter: cleared at each grant, steps on every completed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wordCnt <= '0;
    end else if (start) begin
      wordCnt <= '0;
    end else if (advance && !last) begin
      wordCnt <= wordCnt + IDXW'(1);
    end
  end

  // Line base address captured at grant; datapath only, so no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      base <= startAdr & ~OFF_MASK;
    end
  end

  assign wordAdr = base + WORD_LENGTH'({wordCnt, 2'b00});
  assign last    = (wordCnt == IDXW'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_if_arbiter.sv
// Memory interface arbiter: serializes I-cache fills and D-cache fills and
// write-backs onto one word-wide memory port. I has fixed priority, with a
// starvation guard that hands D the next grant after STARVE_LIMIT I grants.
module mem_if_arbiter
  import mem_if_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH  = DFLT_WORD_LENGTH,
  parameter int LINE_WORDS   = DFLT_LINE_WORDS,
  parameter int STARVE_LIMIT = 4,
  localparam int IDXW        = $clog2(LINE_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iReq,
  input  logic [WORD_LENGTH-1:0] iAdr,
  output logic [WORD_LENGTH-1:0] iRData,
  output logic                   iRValid,
  output logic                   iDone,
  input  logic                   dReq,
  input  logic                   dWr,
  input  logic [WORD_LENGTH-1:0] dAdr,
  input  logic [WORD_LENGTH-1:0] dWData,
  output logic [IDXW-1:0]        dWordIdx,
  output logic [WORD_LENGTH-1:0] dRData,
  output logic                   dRValid,
  output logic                   dDone,
  output logic                   memReq,
  output logic                   memWr,
  output logic [WORD_LENGTH-1:0] memAdr,
  output logic [WORD_LENGTH-1:0] memWData,
  input  logic [WORD_LENGTH-1:0] memRData,
  input  logic                   memAck,
  output logic                   busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t                 state;
  state_t                 stateNext;
  owner_t                 owner;
  logic                   wr;
  logic [SW-1:0]          starveCnt;
  logic                   starve;
  logic                   grantI;
  logic                   grantD;
  logic                   seqStart;
  logic                   seqAdvance;
  logic [WORD_LENGTH-1:0] startAdr;
  logic [IDXW-1:0]        wordCnt;
  logic [WORD_LENGTH-1:0] wordAdr;
  logic                   last;

  // I wins unless D has been passed over STARVE_LIMIT times in a row.
  assign starve   = dReq && (starveCnt >= SW'(STARVE_LIMIT));
  assign grantI   = iReq && !starve;
  assign grantD   = dReq && !grantI;
  assign startAdr = grantI ? iAdr : dAdr;
  assign busy     = (state != IDLE);

  mem_burst_seq #(
    .WORD_LENGTH (WORD_LENGTH),
    .LINE_WORDS  (LINE_WORDS)
  ) uSeq (
    .clk      (clk),
    .rst      (rst),
    .start    (seqStart),
    .startAdr (startAdr),
    .advance  (seqAdvance),
    .wordCnt  (wordCnt),
    .wordAdr  (wordAdr),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Grant bookkeeping: owner, direction and the starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_I;
      wr        <= 1'b0;
      starveCnt <= '0;
    end else if ((state == IDLE) && (grantI || grantD)) begin
      owner <= grantI ? OWN_I : OWN_D;
      wr    <= grantD && dWr;
      if (grantI && dReq) begin
        if (starveCnt < SW'(STARVE_LIMIT)) begin
          starveCnt <= starveCnt + SW'(1);
        end
      end else begin
        starveCnt <= '0;
      end
    end
  end

  // Next-state logic and all port outputs; memory data steered to the owner.
  always_comb begin
    stateNext  = state;
    seqStart   = 1'b0;
    seqAdvance = 1'b0;
    memReq     = 1'b0;
    memWr      = 1'b0;
    memAdr     = '0;
    memWData   = '0;
    dWordIdx   = '0;
    iRValid    = 1'b0;
    iRData     = '0;
    dRValid    = 1'b0;
    dRData     = '0;
    iDone      = 1'b0;
    dDone      = 1'b0;
    case (state)
      IDLE: begin
        if (grantI || grantD) begin
          seqStart  = 1'b1;
          stateNext = XFER;
        end
      end
      XFER: begin
        memReq   = 1'b1;
        memWr    = wr;
        memAdr   = wordAdr;
        memWData = dWData;
        dWordIdx = wordCnt;
        if (memAck) begin
          seqAdvance = 1'b1;
          if (!wr) begin
            if (owner == OWN_I) begin
              iRValid = 1'b1;
              iRData  = memRData;
            end else begin
              dRValid = 1'b1;
              dRData  = memRData;
            end
          end
          if (last) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        iDone     = (owner == OWN_I);
        dDone     = (owner == OWN_D);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed self-checking bench for mem_if_arbiter (32-bit words, 4-word lines,
// starvation limit 4).
module tb_mem_if_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq;
  logic [31:0] iAdr;
  logic [31:0] iRData;
  logic        iRValid;
  logic        iDone;
  logic        dReq;
  logic        dWr;
  logic [31:0] dAdr;
  logic [31:0] dWData;
  logic [1:0]  dWordIdx;
  logic [31:0] dRData;
  logic        dRValid;
  logic        dDone;
  logic        memReq;
  logic        memWr;
  logic [31:0] memAdr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memAck;
  logic        busy;

  int testCnt = 0;
  int failCnt = 0;

  mem_if_arbiter #(
    .WORD_LENGTH  (32),
    .LINE_WORDS   (4),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iReq     (iReq),
    .iAdr     (iAdr),
    .iRData   (iRData),
    .iRValid  (iRValid),
    .iDone    (iDone),
    .dReq     (dReq),
    .dWr      (dWr),
    .dAdr     (dAdr),
    .dWData   (dWData),
    .dWordIdx (dWordIdx),
    .dRData   (dRData),
    .dRValid  (dRValid),
    .dDone    (dDone),
    .memReq   (memReq),
    .memWr    (memWr),
    .memAdr   (memAdr),
    .memWData (memWData),
    .memRData (memRData),
    .memAck   (memAck),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    iReq     = 1'b0;
    iAdr     = '0;
    dReq     = 1'b0;
    dWr      = 1'b0;
    dAdr     = '0;
    dWData   = '0;
    memRData = '0;
    memAck   = 1'b0;

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_memReq", memReq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iRValid", iRValid, 0);
    chk("rst_dRValid", dRValid, 0);
    chk("rst_iDone", iDone, 0);
    chk("rst_dDone", dDone, 0);
    chk("rst_memAdr", memAdr, 0);
    chk("rst_memWr", memWr, 0);
    chk("rst_dWordIdx", dWordIdx, 0);
    chk("rst_starveCnt", dut.starveCnt, 0);
    rst = 1'b0;

    // I fill, zero wait
    cyc();
    iReq   = 1'b1;
    iAdr   = 32'h0000_1234;
    memAck = 1'b1;
    #1;
    chk("i0_idle_busy", busy, 0);
    chk("i0_idle_rvalid", iRValid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      memRData = 32'hA000_0000 + k;
      #1;
      chk("i0_memReq", memReq, 1);
      chk("i0_memWr", memWr, 0);
      chk("i0_memAdr", memAdr, 32'h0000_1230 + 4 * k);
      chk("i0_iRValid", iRValid, 1);
      chk("i0_iRData", iRData, 32'hA000_0000 + k);
      chk("i0_dRValid", dRValid, 0);
    end
    cyc();
    iReq = 1'b0;
    #1;
    chk("i0_iDone", iDone, 1);
    chk("i0_done_memReq", memReq, 0);
    chk("i0_done_busy", busy, 1);
    chk("i0_done_iRValid", iRValid, 0);
    cyc();
    #1;
    chk("i0_back_idle", busy, 0);
    chk("i0_iDone_once", iDone, 0);

    // D write-back, memAck every third cycle
    memAck = 1'b0;
    dReq   = 1'b1;
    dWr    = 1'b1;
    dAdr   = 32'h8000_0040;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        cyc();
        memAck = (w == 2);
        dWData = 32'hC0DE_0000 + k;
        #1;
        chk("dw_memReq", memReq, 1);
        chk("dw_memWr", memWr, 1);
        chk("dw_dWordIdx", dWordIdx, k);
        chk("dw_memAdr", memAdr, 32'h8000_0040 + 4 * k);
        chk("dw_memWData", memWData, 32'hC0DE_0000 + k);
        chk("dw_dRValid", dRValid, 0);
        chk("dw_dDone_early", dDone, 0);
      end
    end
    cyc();
    memAck = 1'b0;
    dReq   = 1'b0;
    dWr    = 1'b0;
    #1;
    chk("dw_dDone", dDone, 1);
    chk("dw_iDone", iDone, 0);
    chk("dw_done_dRValid", dRValid, 0);
    cyc();
    #1;
    chk("dw_dDone_once", dDone, 0);
    chk("dw_idle", busy, 0);

    // Simultaneous requests: I first, then D
    iReq   = 1'b1;
    iAdr   = 32'h0000_0100;
    dReq   = 1'b1;
    dAdr   = 32'h0000_0200;
    memAck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      memRData = 32'h1111_0000 + k;
      #1;
      chk("sim_iRValid", iRValid, 1);
      chk("sim_dRValid", dRValid, 0);
      chk("sim_i_memAdr", memAdr, 32'h0000_0100 + 4 * k);
      chk("sim_starve_wait", dut.starveCnt, 1);
    end
    cyc();
    iReq = 1'b0;
    #1;
    chk("sim_iDone", iDone, 1);
    cyc();
    #1;
    chk("sim_idle", busy, 0);
    chk("sim_starve_idle", dut.starveCnt, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      memRData = 32'h2222_0000 + k;
      #1;
      chk("sim_dRValid", dRValid, 1);
      chk("sim_dRData", dRData, 32'h2222_0000 + k);
      chk("sim_iRValid_d", iRValid, 0);
      chk("sim_d_memAdr", memAdr, 32'h0000_0200 + 4 * k);
      chk("sim_starve_clr", dut.starveCnt, 0);
    end
    cyc();
    dReq = 1'b0;
    #1;
    chk("sim_dDone", dDone, 1);
    cyc();
    #1;
    chk("sim_idle2", busy, 0);

    // Starvation: both held, expected grant order I,I,I,I,D,I
    iReq = 1'b1;
    dReq = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        cyc();
        #1;
        chk("stv_iRValid", iRValid, (b != 4));
        chk("stv_dRValid", dRValid, (b == 4));
      end
      cyc();
      if (b == 5) begin
        iReq = 1'b0;
        dReq = 1'b0;
      end
      #1;
      chk("stv_iDone", iDone, (b != 4));
      chk("stv_dDone", dDone, (b == 4));
      cyc();
      #1;
      chk("stv_idle", busy, 0);
    end

    // Reset after the second memAck of an I fill
    iReq = 1'b1;
    iAdr = 32'h0000_0400;
    cyc();
    #1;
    chk("rmb_w0_adr", memAdr, 32'h0000_0400);
    cyc();
    #1;
    chk("rmb_w1_adr", memAdr, 32'h0000_0404);
    cyc();
    rst    = 1'b1;
    memAck = 1'b0;
    #1;
    cyc();
    #1;
    chk("rmb_memReq", memReq, 0);
    chk("rmb_busy", busy, 0);
    chk("rmb_iDone", iDone, 0);
    rst    = 1'b0;
    memAck = 1'b1;
    #1;
    chk("rmb_idle", busy, 0);
    cyc();
    #1;
    chk("rmb_restart_adr", memAdr, 32'h0000_0400);
    chk("rmb_restart_idx", dWordIdx, 0);
    chk("rmb_restart_rvalid", iRValid, 1);
    for (int k = 1; k < 4; k++) begin
      cyc();
      #1;
      chk("rmb_adr", memAdr, 32'h0000_0400 + 4 * k);
    end
    cyc();
    iReq = 1'b0;
    #1;
    chk("rmb_iDone_end", iDone, 1);
    cyc();
    #1;
    chk("rmb_idle_end", busy, 0);

    // Spurious ack in IDLE, then address wrap at the top of memory
    cyc();
    #1;
    chk("spur_iRValid", iRValid, 0);
    chk("spur_dRValid", dRValid, 0);
    chk("spur_busy", busy, 0);
    cyc();
    #1;
    chk("spur_busy2", busy, 0);
    chk("spur_memReq", memReq, 0);
    iReq = 1'b1;
    iAdr = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk("wrap_memAdr", memAdr, 32'hFFFF_FFF0 + 4 * k);
    end
    cyc();
    iReq   = 1'b0;
    memAck = 1'b0;
    #1;
    chk("wrap_iDone", iDone, 1);
    cyc();
    #1;
    chk("wrap_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
